mod241_residue_accumulator: RTL
===============================

// Module: mod241_residue_accumulator
// PURPOSE
//  Sink end of the mod-241 chunk LUT bank: takes the stream of 8-bit partial residues the 6-input LUTs
//  produce, one chunk per beat, and folds them into one reduced residue per operand frame (x mod 241).
//  Sits after the LUT bank on a valid/ready stream; one result per frame, presented on a held output handshake.
// PARAMETERS
//  MODULUS     241  modulus; must satisfy 2^W-2 < 2*MODULUS and MODULUS < 2^W
//  W           8    width of partial residues and of the result
//  MAX_CHUNKS  84   max beats per frame (500-bit operand / 6-bit chunks); used only with MOD241_OVF_EN
//  CW          7    beat-counter width; must satisfy 2^CW > MAX_CHUNKS
// PORTS
//  clk        in   1   clock, rising edge
//  rst        in   1   asynchronous, active-high reset
//  s_valid    in   1   partial residue valid
//  s_ready    out  1   accumulator can take a beat
//  s_data     in   W   partial residue, 0..2^W-1 (need not be < MODULUS)
//  s_last     in   1   final chunk of the current frame
//  m_valid    out  1   result valid, held until m_ready
//  m_ready    in   1   downstream accepts result
//  m_data     out  W   frame residue, 0..MODULUS-1
//  frame_err  out  1   frame exceeded MAX_CHUNKS beats (MOD241_OVF_EN only; else constant 0)
// BEHAVIOUR
//  - Reset (async): state=ACCUM, acc=0, cnt=0, m_valid=0, m_data=0, frame_err=0. Reset mid-frame discards the partial sum.
//  - States: ACCUM (s_ready=1), HOLD (s_ready=0, m_valid=1).
//  - Beat accepted when s_valid & s_ready. sum = acc + s_data (W+1 bits, max 495); red = sum - k*MODULUS,
//    k in {0,1,2}, chosen so that 0 <= red < MODULUS (two compare/subtract steps, combinational, same cycle).
//  - Beat with s_last=0: acc<=red, cnt<=cnt+1; stay in ACCUM.
//  - Beat with s_last=1: m_data<=red, m_valid<=1, acc<=0, cnt<=0, go to HOLD. Latency: result valid the
//    cycle after the last beat is accepted. A one-beat frame is legal.
//  - HOLD: m_data/m_valid/frame_err stable while m_ready=0. On m_ready=1: m_valid<=0, go to ACCUM;
//    s_ready returns to 1 the next cycle (no same-cycle drain/accept bypass).
//  - s_data/s_last are ignored when s_valid=0 or s_ready=0. m_ready is ignored in ACCUM.
//  - Data with s_data >= MODULUS is valid input, not an error; it is reduced like any other value.
// CONFIGURATION
//  MOD241_OVF_EN defined: cnt saturates at 2^CW-1. If a frame's beat count (including the last beat)
//    exceeds MAX_CHUNKS, frame_err<=1 together with m_valid. The result is still computed over all beats.
//    frame_err clears when the result handshake completes.
//  MOD241_OVF_EN undefined: no counter logic; frame_err tied to 0; frames of any length are accepted.
// TESTING
//  1. Assert rst mid-clock, release -> m_valid=0, s_ready=1, m_data=0, frame_err=0.
//  2. Single beat s_data=241, s_last=1 -> next cycle m_valid=1, m_data=0.
//  3. Beats 240, 255 (s_last on the 2nd) -> m_data=13. Same frame then 240, 255, 1 (last) -> m_data=14.
//  4. m_ready=0 for 5 cycles after result -> s_ready=0, m_data held, offered beats not consumed;
//     m_ready=1 -> m_valid=0 the next cycle, s_ready=1.
//  5. Beats 100, 100, then rst, then 50 (last) -> m_data=50 (earlier partial sum discarded).
//  6. 85 beats of 1 (last on 85th) -> m_data=85; frame_err=1 with MOD241_OVF_EN, 0 without; 84 beats -> frame_err=0.

Source files
------------

// File: rtl/mod241_residue_accumulator_if.sv
// Stream bundle for the mod-241 residue accumulator: partial-residue input beats and the
// per-frame result handshake. The accumulator takes the slave modport.
interface mod241_residue_accumulator_if #(
  parameter int unsigned W = 8
) ();

  // Partial-residue stream from the LUT bank
  logic         s_valid;
  logic         s_ready;
  logic [W-1:0] s_data;
  logic         s_last;

  // Frame result towards the consumer
  logic         m_valid;
  logic         m_ready;
  logic [W-1:0] m_data;
  logic         frame_err;

  modport master (
    output s_valid,
    output s_data,
    output s_last,
    output m_ready,
    input  s_ready,
    input  m_valid,
    input  m_data,
    input  frame_err
  );

  modport slave (
    input  s_valid,
    input  s_data,
    input  s_last,
    input  m_ready,
    output s_ready,
    output m_valid,
    output m_data,
    output frame_err
  );

endinterface

// File: rtl/mod241_residue_accumulator.sv
// Folds a stream of W-bit partial residues into one residue (mod MODULUS) per frame.
// Optional beat-count overflow flag is built when MOD241_OVF_EN is defined.
module mod241_residue_accumulator #(
  parameter int unsigned MODULUS    = 241,
  parameter int unsigned W          = 8,
  parameter int unsigned MAX_CHUNKS = 84,
  parameter int unsigned CW         = 7
) (
  input logic                         clk,
  input logic                         rst,
  mod241_residue_accumulator_if.slave bus
);

  localparam logic [0:0] StAccum = 1'b0;
  localparam logic [0:0] StHold  = 1'b1;

  localparam logic [W:0] ModExt = MODULUS[W:0];

  logic [0:0]   state_q, state_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] m_data_q, m_data_d;

  logic         beat;
  logic [W:0]   sum;
  logic [W:0]   red_one;
  logic [W:0]   red_two;
  logic [W-1:0] red;

  assign bus.s_ready = (state_q == StAccum);
  assign bus.m_valid = (state_q == StHold);
  assign bus.m_data  = m_data_q;

  assign beat = bus.s_valid & bus.s_ready;

  // acc < MODULUS and s_data < 2^W keep sum below 3*MODULUS, so two conditional
  // subtractions always land in 0..MODULUS-1.
  assign sum     = {1'b0, acc_q} + {1'b0, bus.s_data};
  assign red_one = (sum >= ModExt) ? (sum - ModExt) : sum;
  assign red_two = (red_one >= ModExt) ? (red_one - ModExt) : red_one;
  assign red     = red_two[W-1:0];

  logic unused_red_msb;
  assign unused_red_msb = red_two[W];

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    m_data_d = m_data_q;
    unique case (state_q)
      StAccum: begin
        if (beat) begin
          if (bus.s_last) begin
            m_data_d = red;
            acc_d    = '0;
            state_d  = StHold;
          end else begin
            acc_d = red;
          end
        end
      end
      StHold: begin
        // No drain/accept bypass: s_ready only reasserts the cycle after the handshake.
        if (bus.m_ready) begin
          state_d = StAccum;
        end
      end
      default: state_d = StAccum;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StAccum;
      acc_q    <= '0;
      m_data_q <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      m_data_q <= m_data_d;
    end
  end

`ifdef MOD241_OVF_EN

  localparam logic [CW:0] CntOne  = (CW + 1)'(1);
  localparam logic [CW:0] MaxBeat = MAX_CHUNKS[CW:0];

  logic [CW-1:0] cnt_q, cnt_d;
  logic          frame_err_q, frame_err_d;
  logic [CW:0]   beats;

  // Beats seen so far in this frame, counting the one being offered now.
  assign beats = {1'b0, cnt_q} + CntOne;

  assign bus.frame_err = frame_err_q;

  always_comb begin
    cnt_d       = cnt_q;
    frame_err_d = frame_err_q;
    if (beat) begin
      if (bus.s_last) begin
        cnt_d       = '0;
        frame_err_d = (beats > MaxBeat);
      end else if (!(&cnt_q)) begin
        cnt_d = beats[CW-1:0];
      end
    end else if ((state_q == StHold) && bus.m_ready) begin
      frame_err_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      frame_err_q <= frame_err_d;
    end
  end

  a_err_with_valid: assert property (@(posedge clk) disable iff (rst)
    bus.frame_err |-> bus.m_valid);

`else

  assign bus.frame_err = 1'b0;

  // Counter configuration only matters for the overflow flag.
  logic unused_cfg;
  assign unused_cfg = (MAX_CHUNKS < (2 ** CW));

`endif

  a_result_held: assert property (@(posedge clk) disable iff (rst)
    (bus.m_valid && !bus.m_ready) |=> (bus.m_valid && $stable(bus.m_data)
                                       && $stable(bus.frame_err)));

  a_red_in_range: assert property (@(posedge clk) disable iff (rst)
    beat |-> (red_two < ModExt));

  a_ready_excl: assert property (@(posedge clk) disable iff (rst)
    !(bus.s_ready && bus.m_valid));

endmodule
